// File: rtl/mux_pkt_arbiter_pkg.sv
// Shared encodings for the packet arbiter: flit types, one-hot mux selects and FSM states.
// Also provides the helper that extracts the type field from a full flit.
package mux_pkt_arbiter_pkg;

    localparam int DATAW = 66;

    typedef enum logic [1:0] {
        TYPE_NONE = 2'b00,
        TYPE_HEAD = 2'b01,
        TYPE_DATA = 2'b10,
        TYPE_TAIL = 2'b11
    } flit_type_e;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_P0   = 2'b01;
    localparam logic [1:0] SEL_P1   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOCK0 = 2'b01,
        ST_LOCK1 = 2'b10
    } state_e;

    // Type field occupies the two MSBs of a flit.
    function automatic logic [1:0] flit_type(input logic [DATAW-1:0] flit);
        return flit[DATAW-1 -: 2];
    endfunction

endpackage

// File: rtl/mux_pkt_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port i_ptr names.
// Purely combinational; the output is already in one-hot mux-select form.
module mux_pkt_arbiter_rr_arb2
    import mux_pkt_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = i_req;
        if (&i_req) begin
            o_grant = i_ptr ? SEL_P1 : SEL_P0;
        end
    end

endmodule

// File: rtl/mux_pkt_arbiter.sv
// Packet-level round-robin arbiter for the router's 2:1 output mux. Locks one input from
// head to tail, drives the mux select and per-input grants, and flags over-length packets.
module mux_pkt_arbiter
    import mux_pkt_arbiter_pkg::*;
#(
    parameter int SELW    = 2,
    parameter int MAX_LEN = 64,
    parameter int CNTW    = 7
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            ivalid_0,
    input  logic [1:0]      itype_0,
    input  logic            ivalid_1,
    input  logic [1:0]      itype_1,
    input  logic            oready,
    output logic [SELW-1:0] sel,
    output logic            grant_0,
    output logic            grant_1,
    output logic            busy,
    output logic            err_len
);

    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAX_LEN);
    localparam logic [CNTW-1:0] CNT_SAT = CNTW'(MAX_LEN + 1);

    state_e            r_state;
    logic              r_rr_ptr;
    logic [CNTW-1:0]   r_cnt;
    logic              r_err_len;

    logic [1:0]        w_req;
    logic [1:0]        w_pick;
    logic [1:0]        w_sel;
    logic              w_xfer_0;
    logic              w_xfer_1;
    logic              w_xfer;
    logic [1:0]        w_xtype;

    assign w_req[0] = ivalid_0 & (itype_0 == TYPE_HEAD);
    assign w_req[1] = ivalid_1 & (itype_1 == TYPE_HEAD);

    mux_pkt_arbiter_rr_arb2 u_rr_arb2 (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick)
    );

    // Idle shows the candidate head immediately; a lock pins the select to its port.
    always_comb begin
        w_sel = SEL_NONE;
        unique case (r_state)
            ST_IDLE:  w_sel = w_pick;
            ST_LOCK0: w_sel = SEL_P0;
            ST_LOCK1: w_sel = SEL_P1;
            default:  w_sel = SEL_NONE;
        endcase
    end

    // A valid-but-NONE flit is a bubble: it neither transfers nor advances the packet.
    assign w_xfer_0 = ivalid_0 & (itype_0 != TYPE_NONE) & oready & w_sel[0];
    assign w_xfer_1 = ivalid_1 & (itype_1 != TYPE_NONE) & oready & w_sel[1];
    assign w_xfer   = w_xfer_0 | w_xfer_1;
    assign w_xtype  = w_sel[1] ? itype_1 : itype_0;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= 1'b0;
            r_cnt     <= '0;
            r_err_len <= 1'b0;
        end else if (w_xfer) begin
            unique case (r_state)
                ST_IDLE: begin
                    r_state <= w_xfer_1 ? ST_LOCK1 : ST_LOCK0;
                    r_cnt   <= CNT_ONE;
                end
                ST_LOCK0, ST_LOCK1: begin
                    if (w_xtype == TYPE_HEAD) begin
                        r_cnt <= CNT_ONE;
                    end else begin
                        if (r_cnt >= CNT_MAX) begin
                            r_err_len <= 1'b1;
                        end
                        if (w_xtype == TYPE_TAIL) begin
                            r_state  <= ST_IDLE;
                            r_rr_ptr <= (r_state == ST_LOCK0);
                            r_cnt    <= '0;
                        end else if (r_cnt != CNT_SAT) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sel     = w_sel;
    assign grant_0 = w_xfer_0;
    assign grant_1 = w_xfer_1;
    assign busy    = (r_state != ST_IDLE);
    assign err_len = r_err_len;

endmodule

// File: tb/tb_mux_pkt_arbiter.sv
// Self-checking bench for mux_pkt_arbiter: long packet sequences, length boundary, async
// reset, and a table of contention/stall vectors, with a grant scoreboard alongside.
module tb_mux_pkt_arbiter;
    import mux_pkt_arbiter_pkg::*;

    localparam int MAXL = 64;
    localparam logic [1:0] NN = 2'b00;
    localparam logic [1:0] HD = 2'b01;
    localparam logic [1:0] DT = 2'b10;
    localparam logic [1:0] TL = 2'b11;
    localparam int NVEC = 34;

    typedef struct {
        logic       v0;
        logic [1:0] t0;
        logic       v1;
        logic [1:0] t1;
        logic       rdy;
        logic [1:0] esel;
        logic       eg0;
        logic       eg1;
        logic       ebusy;
    } vec_t;

    typedef struct packed {
        logic       port;
        logic [1:0] ftype;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_;
    logic       ivalid_0, ivalid_1, oready;
    logic [1:0] itype_0, itype_1;
    logic [1:0] sel;
    logic       grant_0, grant_1, busy, err_len;

    int   total = 0;
    int   bad   = 0;
    int   g0_count = 0;
    sb_t  sbq[$];
    vec_t vt[NVEC];

    mux_pkt_arbiter #(.SELW(2), .MAX_LEN(MAXL), .CNTW(7)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .ivalid_0 (ivalid_0),
        .itype_0  (itype_0),
        .ivalid_1 (ivalid_1),
        .itype_1  (itype_1),
        .oready   (oready),
        .sel      (sel),
        .grant_0  (grant_0),
        .grant_1  (grant_1),
        .busy     (busy),
        .err_len  (err_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; drives one cycle of flits and checks mid-cycle.
    task automatic drive_cycle(input logic v0, input logic [1:0] t0, input logic v1,
                               input logic [1:0] t1, input logic rdy, input logic [1:0] esel,
                               input logic eg0, input logic eg1, input logic ebusy,
                               input logic eerr, input string tag);
        logic [DATAW-1:0] f0, f1;
        f0 = {t0, {2{$urandom()}}};
        f1 = {t1, {2{$urandom()}}};
        ivalid_0 = v0;
        itype_0  = flit_type(f0);
        ivalid_1 = v1;
        itype_1  = flit_type(f1);
        oready   = rdy;
        if (eg0) sbq.push_back('{port: 1'b0, ftype: t0});
        if (eg1) sbq.push_back('{port: 1'b1, ftype: t1});
        @(negedge clk);
        #1;
        chk({tag, " sel"}, 32'(sel), 32'(esel));
        chk({tag, " grant_0"}, 32'(grant_0), 32'(eg0));
        chk({tag, " grant_1"}, 32'(grant_1), 32'(eg1));
        chk({tag, " busy"}, 32'(busy), 32'(ebusy));
        chk({tag, " err_len"}, 32'(err_len), 32'(eerr));
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt0(input int len, input logic eerr, input string tag);
        logic [1:0] t;
        for (int k = 0; k < len; k++) begin
            t = (k == 0) ? HD : ((k == len - 1) ? TL : DT);
            drive_cycle(1'b1, t, 1'b0, NN, 1'b1, SEL_P0, 1'b1, 1'b0, (k != 0), eerr, tag);
        end
    endtask

    function automatic vec_t mk(input logic v0, input logic [1:0] t0, input logic v1,
                                input logic [1:0] t1, input logic rdy, input logic [1:0] esel,
                                input logic eg0, input logic eg1, input logic ebusy);
        vec_t v;
        v.v0 = v0; v.t0 = t0; v.v1 = v1; v.t1 = t1; v.rdy = rdy;
        v.esel = esel; v.eg0 = eg0; v.eg1 = eg1; v.ebusy = ebusy;
        return v;
    endfunction

    // Scoreboard: every observed grant must match the next expected transfer.
    always @(negedge clk) begin
        sb_t e;
        logic [1:0] act_type;
        if (grant_0 & grant_1) begin
            total++;
            bad++;
            $display("FAIL sb_onehot: got grant_0=1 grant_1=1 required at most one");
        end else if (grant_0 | grant_1) begin
            act_type = grant_1 ? itype_1 : itype_0;
            if (grant_0) g0_count++;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got grant on port %0d required no grant", grant_1);
            end else begin
                e = sbq.pop_front();
                chk("sb_port", 32'(grant_1), 32'(e.port));
                chk("sb_type", 32'(act_type), 32'(e.ftype));
                $display("xfer port=%0d type=%0d pending=%0d", grant_1, act_type, sbq.size());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // contention, back-to-back handover, third contention
        vt[0]  = mk(1'b1, HD, 1'b1, HD, 1'b1, SEL_P0,   1'b1, 1'b0, 1'b0);
        vt[1]  = mk(1'b1, DT, 1'b1, HD, 1'b1, SEL_P0,   1'b1, 1'b0, 1'b1);
        vt[2]  = mk(1'b1, TL, 1'b1, HD, 1'b1, SEL_P0,   1'b1, 1'b0, 1'b1);
        vt[3]  = mk(1'b0, NN, 1'b1, HD, 1'b1, SEL_P1,   1'b0, 1'b1, 1'b0);
        vt[4]  = mk(1'b0, NN, 1'b1, DT, 1'b1, SEL_P1,   1'b0, 1'b1, 1'b1);
        vt[5]  = mk(1'b0, NN, 1'b1, TL, 1'b1, SEL_P1,   1'b0, 1'b1, 1'b1);
        vt[6]  = mk(1'b1, HD, 1'b1, HD, 1'b1, SEL_P0,   1'b1, 1'b0, 1'b0);
        vt[7]  = mk(1'b1, TL, 1'b1, HD, 1'b1, SEL_P0,   1'b1, 1'b0, 1'b1);
        vt[8]  = mk(1'b0, NN, 1'b1, HD, 1'b1, SEL_P1,   1'b0, 1'b1, 1'b0);
        vt[9]  = mk(1'b0, NN, 1'b1, TL, 1'b1, SEL_P1,   1'b0, 1'b1, 1'b1);
        // port 1 head arrives mid-way through a port 0 packet
        vt[10] = mk(1'b1, HD, 1'b0, NN, 1'b1, SEL_P0,   1'b1, 1'b0, 1'b0);
        vt[11] = mk(1'b1, DT, 1'b1, HD, 1'b1, SEL_P0,   1'b1, 1'b0, 1'b1);
        vt[12] = mk(1'b1, DT, 1'b1, HD, 1'b1, SEL_P0,   1'b1, 1'b0, 1'b1);
        vt[13] = mk(1'b1, TL, 1'b1, HD, 1'b1, SEL_P0,   1'b1, 1'b0, 1'b1);
        vt[14] = mk(1'b0, NN, 1'b1, HD, 1'b1, SEL_P1,   1'b0, 1'b1, 1'b0);
        vt[15] = mk(1'b0, NN, 1'b1, TL, 1'b1, SEL_P1,   1'b0, 1'b1, 1'b1);
        // oready low for three cycles mid-packet
        vt[16] = mk(1'b1, HD, 1'b0, NN, 1'b1, SEL_P0,   1'b1, 1'b0, 1'b0);
        vt[17] = mk(1'b1, DT, 1'b0, NN, 1'b1, SEL_P0,   1'b1, 1'b0, 1'b1);
        vt[18] = mk(1'b1, DT, 1'b0, NN, 1'b0, SEL_P0,   1'b0, 1'b0, 1'b1);
        vt[19] = mk(1'b1, DT, 1'b0, NN, 1'b0, SEL_P0,   1'b0, 1'b0, 1'b1);
        vt[20] = mk(1'b1, DT, 1'b0, NN, 1'b0, SEL_P0,   1'b0, 1'b0, 1'b1);
        vt[21] = mk(1'b1, DT, 1'b0, NN, 1'b1, SEL_P0,   1'b1, 1'b0, 1'b1);
        vt[22] = mk(1'b1, TL, 1'b0, NN, 1'b1, SEL_P0,   1'b1, 1'b0, 1'b1);
        // idle contention with oready low: candidate shown, no lock taken
        vt[23] = mk(1'b1, HD, 1'b1, HD, 1'b0, SEL_P1,   1'b0, 1'b0, 1'b0);
        vt[24] = mk(1'b1, HD, 1'b1, HD, 1'b0, SEL_P1,   1'b0, 1'b0, 1'b0);
        vt[25] = mk(1'b1, HD, 1'b1, HD, 1'b1, SEL_P1,   1'b0, 1'b1, 1'b0);
        vt[26] = mk(1'b1, HD, 1'b1, TL, 1'b1, SEL_P1,   1'b0, 1'b1, 1'b1);
        // non-head flits while idle are stalled
        vt[27] = mk(1'b1, DT, 1'b0, NN, 1'b1, SEL_NONE, 1'b0, 1'b0, 1'b0);
        vt[28] = mk(1'b0, NN, 1'b1, TL, 1'b1, SEL_NONE, 1'b0, 1'b0, 1'b0);
        // NONE bubble while locked, then a head restarting the packet
        vt[29] = mk(1'b1, HD, 1'b0, NN, 1'b1, SEL_P0,   1'b1, 1'b0, 1'b0);
        vt[30] = mk(1'b1, NN, 1'b0, NN, 1'b1, SEL_P0,   1'b0, 1'b0, 1'b1);
        vt[31] = mk(1'b1, HD, 1'b0, NN, 1'b1, SEL_P0,   1'b1, 1'b0, 1'b1);
        vt[32] = mk(1'b1, TL, 1'b0, NN, 1'b1, SEL_P0,   1'b1, 1'b0, 1'b1);
        vt[33] = mk(1'b0, NN, 1'b0, NN, 1'b1, SEL_NONE, 1'b0, 1'b0, 1'b0);

        ivalid_0 = 1'b0; itype_0 = NN;
        ivalid_1 = 1'b0; itype_1 = NN;
        oready   = 1'b0;
        rst_     = 1'b1;
        #2 rst_  = 1'b0;
        #2;
        chk("rst sel", 32'(sel), 32'(SEL_NONE));
        chk("rst grant_0", 32'(grant_0), 32'd0);
        chk("rst grant_1", 32'(grant_1), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst err_len", 32'(err_len), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_ = 1'b1;

        // 22-flit packet on port 0
        g0_count = 0;
        send_pkt0(22, 1'b0, "t1");
        drive_cycle(1'b0, NN, 1'b0, NN, 1'b1, SEL_NONE, 1'b0, 1'b0, 1'b0, 1'b0, "t1_end");
        chk("t1 grant_0 count", 32'(g0_count), 32'd22);

        // exactly MAX_LEN flits: no error
        send_pkt0(MAXL, 1'b0, "len_max");
        drive_cycle(1'b0, NN, 1'b0, NN, 1'b1, SEL_NONE, 1'b0, 1'b0, 1'b0, 1'b0, "len_max_end");

        // MAX_LEN+1 flits: error after the last flit, sticky afterwards
        send_pkt0(MAXL + 1, 1'b0, "len_over");
        drive_cycle(1'b0, NN, 1'b0, NN, 1'b1, SEL_NONE, 1'b0, 1'b0, 1'b0, 1'b1, "len_over_end");
        send_pkt0(2, 1'b1, "after_err");
        drive_cycle(1'b0, NN, 1'b0, NN, 1'b1, SEL_NONE, 1'b0, 1'b0, 1'b0, 1'b1, "after_err_end");

        // async reset mid-packet (rr_ptr is 1 here, so the later contention shows it cleared)
        drive_cycle(1'b1, HD, 1'b0, NN, 1'b1, SEL_P0, 1'b1, 1'b0, 1'b0, 1'b1, "t6");
        drive_cycle(1'b1, DT, 1'b0, NN, 1'b1, SEL_P0, 1'b1, 1'b0, 1'b1, 1'b1, "t6");
        ivalid_0 = 1'b1; itype_0 = DT; oready = 1'b1;
        #1 rst_ = 1'b0;
        #1;
        chk("t6 async sel", 32'(sel), 32'(SEL_NONE));
        chk("t6 async busy", 32'(busy), 32'd0);
        chk("t6 async grant_0", 32'(grant_0), 32'd0);
        chk("t6 async err_len", 32'(err_len), 32'd0);
        @(posedge clk);
        #1;
        chk("t6 held busy", 32'(busy), 32'd0);
        ivalid_0 = 1'b0; itype_0 = NN;
        #2 rst_ = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            drive_cycle(vt[i].v0, vt[i].t0, vt[i].v1, vt[i].t1, vt[i].rdy, vt[i].esel,
                        vt[i].eg0, vt[i].eg1, vt[i].ebusy, 1'b0, $sformatf("vec%0d", i));
        end

        chk("sb drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
